fifo_burst_reader: RTL and testbench

- Downstream consumer of sync_fifo. Drains the FIFO in bursts of a configurable length and presents the words on a valid/ready stream, with m_last on the final beat of each burst.
- Absorbs the FIFO's 1-cycle read latency (rd_en → rd_data_vld) with a small output buffer, so there is no data loss under backpressure.
- Sustains one word per cycle when m_ready=1.
- A flush request drains a partial burst.

---
 rtl/fifo_burst_pkg.sv | 9 +
 rtl/burst_out_buf.sv | 37 +++
 rtl/fifo_burst_reader.sv | 68 ++++++
 tb/tb_fifo_burst_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg: FSM state encoding and burst-length clamp shared by fifo_burst_reader
package fifo_burst_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned deepwid);
    int unsigned max_len;
    max_len = 32'd1 << deepwid;
    return (len == 0) ? 32'd1 : (len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/burst_out_buf.sv
// burst_out_buf: first-word-fall-through {data,last} buffer (push/push_data in, pop in, count/head out)
module burst_out_buf #(
  parameter int DEPTH = 3,
  parameter int W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [W-1:0]               head
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign head = mem[rd_ptr];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= push_data;
      wr_ptr <= do_push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= do_pop ? nxt(rd_ptr) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains sync_fifo in bursts (fifo_* read side, cfg_burst_len/flush control) onto an m_valid/m_data/m_last/m_ready stream, busy when not IDLE
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DEEPWID = 3,
  parameter int BITWID = 5,
  parameter int OBUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DEEPWID:0]  fifo_num,
  output logic              fifo_rd_en,
  input  logic [BITWID-1:0] fifo_rd_data,
  input  logic              fifo_rd_data_vld,
  input  logic [DEEPWID:0]  cfg_burst_len,
  input  logic              flush,
  output logic              m_valid,
  output logic [BITWID-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [DEEPWID:0] ONE = (DEEPWID+1)'(1);
  state_t state;
  logic [DEEPWID:0] remaining, eff;
  logic flush_pend, inflight, inflight_last;
  logic [CW-1:0] buf_count;
  logic [CW:0] occ;
  logic [BITWID:0] head;
  logic start_norm, start_flush, drop_flush, last_rd, last_beat;
  assign eff = (DEEPWID+1)'(eff_len(32'(cfg_burst_len), DEEPWID));
  // words already buffered plus the one still coming back from the FIFO
  assign occ = {1'b0, buf_count} + (CW+1)'(inflight);
  assign fifo_rd_en = state == READ && !fifo_empty && remaining != '0 && occ < (CW+1)'(OBUF_DEPTH);
  assign last_rd = fifo_rd_en && remaining == ONE;
  assign start_norm = state == IDLE && fifo_num >= eff;
  assign start_flush = state == IDLE && !start_norm && flush_pend && !fifo_empty;
  assign drop_flush = state == IDLE && !start_norm && flush_pend && fifo_empty;
  assign m_valid = buf_count != '0;
  assign {m_data, m_last} = head;
  assign last_beat = m_valid && m_ready && m_last;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      flush_pend <= 1'b0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= (start_norm || start_flush) ? READ : last_rd ? DRAIN : (state == DRAIN && last_beat) ? IDLE : state;
      remaining <= start_norm ? eff : start_flush ? fifo_num : fifo_rd_en ? remaining - ONE : remaining;
      flush_pend <= flush || (flush_pend && !start_flush && !drop_flush);
      inflight <= fifo_rd_en;
      inflight_last <= last_rd;
    end
  burst_out_buf #(.DEPTH(OBUF_DEPTH), .W(BITWID + 1)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .push(fifo_rd_data_vld && inflight),
    .push_data({fifo_rd_data, inflight_last}),
    .pop(m_valid && m_ready),
    .count(buf_count),
    .head(head)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with a sync_fifo model and a burst-rule beat predictor
module tb_fifo_burst_reader;
  localparam int DEEPWID = 3, BITWID = 5, OBUF_DEPTH = 3;
  typedef struct { int data; bit last; } beat_t;
  logic clk = 0, rst_n = 1, fifo_empty = 1, fifo_rd_en, fifo_rd_data_vld = 0, flush = 0;
  logic m_valid, m_last, m_ready = 1, busy;
  logic [DEEPWID:0] fifo_num = '0, cfg_burst_len = '0;
  logic [BITWID-1:0] fifo_rd_data = '0, m_data;
  int fifo_q[$];
  beat_t exp_q[$];
  int ws[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, occ = 0, occ_max = 0, wcyc = 0, n = 0;
  int rd_cnt, rd_first, rd_last, beat_cnt, beat_first, beat_last, busy_seen;
  bit rd_s;
  always #5 clk = ~clk;
  fifo_burst_reader #(.DEEPWID(DEEPWID), .BITWID(BITWID), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_num(fifo_num),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_data_vld(fifo_rd_data_vld),
    .cfg_burst_len(cfg_burst_len), .flush(flush), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy)
  );
  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  function automatic int model_len(input int cfg);
    return cfg == 0 ? 1 : cfg > (1 << DEEPWID) ? (1 << DEEPWID) : cfg;
  endfunction
  task automatic clear_stats();
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    beat_cnt = 0; beat_first = -1; beat_last = -1;
    busy_seen = 0; occ_max = 0;
  endtask
  task automatic upd_fifo();
    fifo_num = (DEEPWID+1)'(fifo_q.size());
    fifo_empty = fifo_q.size() == 0;
  endtask
  task automatic write_words(input int w[$]);
    foreach (w[i]) fifo_q.push_back(w[i]);
    upd_fifo();
  endtask
  task automatic exp_beat(input int d, input bit l);
    beat_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask
  task automatic expect_words(input int w[$], input int len);
    foreach (w[i]) exp_beat(w[i], ((i + 1) % len == 0) || (i == w.size() - 1));
  endtask
  task automatic tick();
    beat_t e;
    @(negedge clk);
    rd_s = 0;
    if (rst_n) begin
      rd_s = fifo_rd_en;
      busy_seen |= int'(busy);
      n_cmp++;
      if (occ + int'(fifo_rd_en) > OBUF_DEPTH) begin
        n_fail++;
        $display("FAIL rd_bound: outstanding+rd=%0d, required <= %0d", occ + int'(fifo_rd_en), OBUF_DEPTH);
      end
      if (fifo_rd_en) begin
        chk("rd_while_empty", fifo_empty, 0);
        rd_cnt++;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0d last %0d, required no beat", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", m_last, e.last);
        end
        beat_cnt++;
        if (beat_first < 0) beat_first = cyc;
        beat_last = cyc;
      end
      occ += int'(fifo_rd_en) - int'(m_valid && m_ready);
      if (occ > occ_max) occ_max = occ;
    end
    @(posedge clk);
    #1;
    cyc++;
    fifo_rd_data_vld = rd_s && fifo_q.size() > 0;
    if (fifo_rd_data_vld) fifo_rd_data = BITWID'(fifo_q.pop_front());
    upd_fifo();
  endtask
  task automatic drain(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      tick();
      k++;
    end
    chk("drain_beats_left", exp_q.size(), 0);
    exp_q.delete();
    chk("busy_after_last", busy, 0);
    repeat (3) tick();
  endtask
  task automatic pulse_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    clear_stats();
    #1 rst_n = 0;
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1;
    tick();
    clear_stats();
    cfg_burst_len = 4;
    ws = '{3, 5, 16, 28};
    wcyc = cyc;
    write_words(ws);
    exp_beat(3, 0); exp_beat(5, 0); exp_beat(16, 0); exp_beat(28, 1);
    drain(20);
    chk("t1_rd_count", rd_cnt, 4);
    chk("t1_rd_start", rd_first - wcyc, 1);
    chk("t1_rd_span", rd_last - rd_first, 3);
    chk("t1_latency", beat_first - rd_first, 2);
    chk("t1_beat_span", beat_last - beat_first, 3);
    chk("t1_busy_seen", busy_seen, 1);
    clear_stats();
    ws = '{9, 14};
    write_words(ws);
    repeat (5) tick();
    chk("t2_no_read_partial", rd_cnt, 0);
    exp_beat(9, 0); exp_beat(14, 1);
    pulse_flush();
    drain(20);
    chk("t2_rd_count", rd_cnt, 2);
    clear_stats();
    ws = '{7};
    write_words(ws);
    repeat (5) tick();
    chk("t2_flush_pend_cleared", rd_cnt, 0);
    expect_words(ws, model_len(4));
    pulse_flush();
    drain(20);
    clear_stats();
    cfg_burst_len = 8;
    ws = '{0, 1, 2, 3, 4, 5, 6, 7};
    write_words(ws);
    expect_words(ws, model_len(8));
    n = 0;
    while (beat_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t3_beats_before_stall", beat_cnt, 2);
    m_ready = 0;
    repeat (5) tick();
    chk("t3_stall_fill", occ_max, OBUF_DEPTH);
    m_ready = 1;
    drain(40);
    chk("t3_rd_count", rd_cnt, 8);
    chk("t3_beat_count", beat_cnt, 8);
    clear_stats();
    cfg_burst_len = 0;
    ws = '{17, 4};
    write_words(ws);
    expect_words(ws, model_len(0));
    drain(20);
    chk("t4_len0_reads", rd_cnt, 2);
    clear_stats();
    cfg_burst_len = 15;
    ws = '{1, 4, 7, 10, 13, 16, 19, 22};
    write_words(ws);
    expect_words(ws, model_len(15));
    drain(40);
    chk("t4_clamp_reads", rd_cnt, 8);
    clear_stats();
    cfg_burst_len = 4;
    pulse_flush();
    repeat (5) tick();
    chk("t5_empty_flush_reads", rd_cnt, 0);
    chk("t5_empty_flush_busy", busy_seen, 0);
    ws = '{25, 22};
    write_words(ws);
    repeat (5) tick();
    chk("t5_flush_dropped", rd_cnt, 0);
    ws = '{30, 26};
    write_words(ws);
    exp_beat(25, 0); exp_beat(22, 0); exp_beat(30, 0); exp_beat(26, 1);
    drain(20);
    chk("t5_rd_count", rd_cnt, 4);
    clear_stats();
    ws = '{1, 2, 3, 4};
    write_words(ws);
    expect_words(ws, model_len(4));
    n = 0;
    while (rd_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_reads_before_reset", rd_cnt, 2);
    rst_n = 0;
    #1;
    chk("t6_rst_rd_en", fifo_rd_en, 0);
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_m_data", m_data, 0);
    chk("t6_rst_m_last", m_last, 0);
    chk("t6_rst_busy", busy, 0);
    exp_q.delete();
    fifo_q.delete();
    fifo_rd_data_vld = 0;
    occ = 0;
    upd_fifo();
    repeat (2) tick();
    rst_n = 1;
    clear_stats();
    repeat (10) tick();
    chk("t6_no_reads_after", rd_cnt, 0);
    chk("t6_no_beats_after", beat_cnt, 0);
    chk("t6_idle_after", busy_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
